// File: rtl/dc_tag_pkg.sv
// Shared definitions for the DC tag bank controller: entry layout, coherence
// state codes, core opcodes, FSM states and the coherence next-state function.
package dc_tag_pkg;

  localparam int unsigned ENTRY_W  = 24;
  localparam int unsigned NUM_SETS = 32;
  localparam int unsigned POS_W    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W    = 18;
  localparam int unsigned LRU_W    = 2;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned REQ_BITS = 5;

  // Entry field offsets: [17:0] tag, [18] spare, [20:19] lru, [23:21] state
  localparam int unsigned TAG_LSB   = 0;
  localparam int unsigned SPARE_BIT = 18;
  localparam int unsigned LRU_LSB   = 19;
  localparam int unsigned STATE_LSB = 21;

  localparam logic [STATE_W-1:0] ST_I  = 3'd0;
  localparam logic [STATE_W-1:0] ST_S  = 3'd1;
  localparam logic [STATE_W-1:0] ST_E  = 3'd2;
  localparam logic [STATE_W-1:0] ST_US = 3'd3;
  localparam logic [STATE_W-1:0] ST_UM = 3'd4;

  // Loads: 0..6 unshared-capable (U), 8..14 shared (S); MOPs from 16
  localparam logic [REQ_BITS-1:0] CORE_LOP_L08U    = 5'd0;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L16U    = 5'd1;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L32U    = 5'd2;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L64U    = 5'd3;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L128U   = 5'd4;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L256U   = 5'd5;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L512U   = 5'd6;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L08S    = 5'd8;
  localparam logic [REQ_BITS-1:0] CORE_LOP_L512S   = 5'd14;
  localparam logic [REQ_BITS-1:0] CORE_MOP_BEGIN   = 5'd16;
  localparam logic [REQ_BITS-1:0] CORE_MOP_COMMIT  = 5'd17;
  localparam logic [REQ_BITS-1:0] CORE_MOP_CSYNC   = 5'd18;
  localparam logic [REQ_BITS-1:0] CORE_MOP_KILL    = 5'd19;
  localparam logic [REQ_BITS-1:0] CORE_MOP_RESTART = 5'd20;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [LRU_W-1:0]   lru;
    logic               spare;
    logic [TAG_W-1:0]   tag;
  } tag_entry_t;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_FWR,
    FSM_RD,
    FSM_WAIT,
    FSM_WR,
    FSM_RESP
  } fsm_state_e;

  function automatic logic [STATE_W-1:0] dc_next_state(
    input logic [REQ_BITS-1:0] req_type,
    input logic [STATE_W-1:0]  state
  );
    logic [STATE_W-1:0] ns;
    ns = state;
    case (req_type)
      CORE_MOP_BEGIN:                  if (state == ST_UM) ns = ST_US;
      CORE_MOP_COMMIT, CORE_MOP_CSYNC: if (state == ST_US) ns = ST_S;
      CORE_MOP_KILL, CORE_MOP_RESTART: ns = ST_I;
      default:                         ns = state;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/dc_tagbank_arb.sv
// Fill/core arbitration for the tag bank: fill wins unless the core has lost
// MAX_STALL consecutive times, in which case the core is forced through.
module dc_tagbank_arb
  import dc_tag_pkg::*;
#(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic core_valid,
  input  logic fill_valid,
  output logic core_ready_c,
  output logic fill_ready_c,
  output logic core_grant_c,
  output logic fill_grant_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] stall_q;
  logic             stall_max;

  assign stall_max    = (stall_q == CNT_W'(MAX_STALL));
  assign core_ready_c = idle & ~reset & (~fill_valid | stall_max);
  assign fill_ready_c = idle & ~reset & ~(core_valid & stall_max);
  assign core_grant_c = core_ready_c & core_valid;
  assign fill_grant_c = fill_ready_c & fill_valid;

  // Count consecutive core losses; any core grant restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (core_grant_c) begin
      stall_q <= '0;
    end else if (core_valid && fill_grant_c && !stall_max) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dc_tagbank_ctrl.sv
// Sequencer for one single-port DC tag bank: core read-modify-write lookups and
// L2 fill writes. Optional DC_TAGCTRL_SKIPWR_EN skips the write-back of hits
// whose coherence state does not change.
module dc_tagbank_ctrl
  import dc_tag_pkg::*;
#(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req_valid,
  input  logic [REQ_BITS-1:0] core_req_type,
  input  logic [POS_W-1:0]    core_req_pos,
  input  logic [TAG_W-1:0]    core_req_tag,
  output logic                core_req_retry,
  output logic                core_ack_valid,
  output logic                core_ack_hit,
  output logic [STATE_W-1:0]  core_ack_state,
  input  logic                core_ack_retry,
  input  logic                fill_req_valid,
  input  logic [POS_W-1:0]    fill_req_pos,
  input  logic [ENTRY_W-1:0]  fill_req_data,
  output logic                fill_req_retry,
  output logic                tb_req_valid,
  output logic                tb_req_we,
  output logic [POS_W-1:0]    tb_req_pos,
  output logic [ENTRY_W-1:0]  tb_req_data,
  input  logic                tb_req_retry,
  input  logic                tb_ack_valid,
  input  logic [ENTRY_W-1:0]  tb_ack_data,
  output logic                tb_ack_retry
);

  fsm_state_e          state_q, state_d;
  logic [REQ_BITS-1:0] type_q, type_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                req_valid_q, req_valid_d;
  logic                req_we_q, req_we_d;
  logic [POS_W-1:0]    req_pos_q, req_pos_d;
  logic [ENTRY_W-1:0]  req_data_q, req_data_d;
  logic                ack_valid_q, ack_valid_d;
  logic                ack_hit_q, ack_hit_d;
  logic [STATE_W-1:0]  ack_state_q, ack_state_d;

  logic core_ready_c, fill_ready_c, core_grant_c, fill_grant_c;

  dc_tagbank_arb #(.MAX_STALL(MAX_STALL)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .idle         (state_q == FSM_IDLE),
    .core_valid   (core_req_valid),
    .fill_valid   (fill_req_valid),
    .core_ready_c (core_ready_c),
    .fill_ready_c (fill_ready_c),
    .core_grant_c (core_grant_c),
    .fill_grant_c (fill_grant_c)
  );

  tag_entry_t         rd_entry, wr_entry;
  logic [STATE_W-1:0] nxt_state;
  logic               lookup_hit, skip_wr;

  assign rd_entry   = tag_entry_t'(tb_ack_data);
  assign nxt_state  = dc_next_state(type_q, rd_entry.state);
  assign lookup_hit = (rd_entry.tag == tag_q) && (rd_entry.state != ST_I);

`ifdef DC_TAGCTRL_SKIPWR_EN
  assign skip_wr = (nxt_state == rd_entry.state);
`else
  assign skip_wr = 1'b0;
`endif

  // Write-back entry: updated state, lru refreshed, tag/spare preserved
  always_comb begin
    wr_entry       = rd_entry;
    wr_entry.state = nxt_state;
    wr_entry.lru   = '1;
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    tag_d       = tag_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_pos_d   = req_pos_q;
    req_data_d  = req_data_q;
    ack_valid_d = ack_valid_q;
    ack_hit_d   = ack_hit_q;
    ack_state_d = ack_state_q;
    case (state_q)
      FSM_IDLE: begin
        if (fill_grant_c) begin
          state_d     = FSM_FWR;
          req_valid_d = 1'b1;
          req_we_d    = 1'b1;
          req_pos_d   = fill_req_pos;
          req_data_d  = fill_req_data;
        end else if (core_grant_c) begin
          state_d     = FSM_RD;
          type_d      = core_req_type;
          tag_d       = core_req_tag;
          req_valid_d = 1'b1;
          req_we_d    = 1'b0;
          req_pos_d   = core_req_pos;
        end
      end
      FSM_FWR: begin
        if (!tb_req_retry) begin
          state_d     = FSM_IDLE;
          req_valid_d = 1'b0;
        end
      end
      FSM_RD: begin
        if (!tb_req_retry) begin
          state_d     = FSM_WAIT;
          req_valid_d = 1'b0;
        end
      end
      FSM_WAIT: begin
        if (tb_ack_valid) begin
          ack_hit_d   = lookup_hit;
          ack_state_d = lookup_hit ? nxt_state : rd_entry.state;
          if (lookup_hit && !skip_wr) begin
            state_d     = FSM_WR;
            req_valid_d = 1'b1;
            req_we_d    = 1'b1;
            req_data_d  = wr_entry;
          end else begin
            state_d     = FSM_RESP;
            ack_valid_d = 1'b1;
          end
        end
      end
      FSM_WR: begin
        if (!tb_req_retry) begin
          state_d     = FSM_RESP;
          req_valid_d = 1'b0;
          ack_valid_d = 1'b1;
        end
      end
      FSM_RESP: begin
        if (!core_ack_retry) begin
          state_d     = FSM_IDLE;
          ack_valid_d = 1'b0;
          ack_hit_d   = 1'b0;
          ack_state_d = '0;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // Reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FSM_IDLE;
      type_q      <= '0;
      tag_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_pos_q   <= '0;
      req_data_q  <= '0;
      ack_valid_q <= 1'b0;
      ack_hit_q   <= 1'b0;
      ack_state_q <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      tag_q       <= tag_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_pos_q   <= req_pos_d;
      req_data_q  <= req_data_d;
      ack_valid_q <= ack_valid_d;
      ack_hit_q   <= ack_hit_d;
      ack_state_q <= ack_state_d;
    end
  end

  assign core_req_retry = ~core_ready_c;
  assign fill_req_retry = ~fill_ready_c;
  assign tb_req_valid   = req_valid_q;
  assign tb_req_we      = req_we_q;
  assign tb_req_pos     = req_pos_q;
  assign tb_req_data    = req_data_q;
  assign core_ack_valid = ack_valid_q;
  assign core_ack_hit   = ack_hit_q;
  assign core_ack_state = ack_state_q;
  assign tb_ack_retry   = (state_q == FSM_RESP) & core_ack_retry;

endmodule

// File: tb/tb_dc_tagbank_ctrl.sv
// Directed bench for dc_tagbank_ctrl with a zero-wait tag bank model.
`timescale 1ns/1ps
module tb_dc_tagbank_ctrl;
  import dc_tag_pkg::*;

`ifdef DC_TAGCTRL_SKIPWR_EN
  localparam bit SKIPWR = 1'b1;
`else
  localparam bit SKIPWR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                core_req_valid;
  logic [REQ_BITS-1:0] core_req_type;
  logic [POS_W-1:0]    core_req_pos;
  logic [TAG_W-1:0]    core_req_tag;
  logic                core_req_retry;
  logic                core_ack_valid;
  logic                core_ack_hit;
  logic [STATE_W-1:0]  core_ack_state;
  logic                core_ack_retry;
  logic                fill_req_valid;
  logic [POS_W-1:0]    fill_req_pos;
  logic [ENTRY_W-1:0]  fill_req_data;
  logic                fill_req_retry;
  logic                tb_req_valid;
  logic                tb_req_we;
  logic [POS_W-1:0]    tb_req_pos;
  logic [ENTRY_W-1:0]  tb_req_data;
  logic                tb_req_retry;
  logic                tb_ack_valid = 1'b0;
  logic [ENTRY_W-1:0]  tb_ack_data = '0;
  logic                tb_ack_retry;

  always #5 clk = ~clk;

  dc_tagbank_ctrl #(.MAX_STALL(4)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_type(core_req_type),
    .core_req_pos(core_req_pos), .core_req_tag(core_req_tag),
    .core_req_retry(core_req_retry), .core_ack_valid(core_ack_valid),
    .core_ack_hit(core_ack_hit), .core_ack_state(core_ack_state),
    .core_ack_retry(core_ack_retry),
    .fill_req_valid(fill_req_valid), .fill_req_pos(fill_req_pos),
    .fill_req_data(fill_req_data), .fill_req_retry(fill_req_retry),
    .tb_req_valid(tb_req_valid), .tb_req_we(tb_req_we),
    .tb_req_pos(tb_req_pos), .tb_req_data(tb_req_data),
    .tb_req_retry(tb_req_retry), .tb_ack_valid(tb_ack_valid),
    .tb_ack_data(tb_ack_data), .tb_ack_retry(tb_ack_retry)
  );

  // Zero-wait bank: read data returns the cycle after the request is taken
  logic [ENTRY_W-1:0] mem [NUM_SETS];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tb_ack_valid <= 1'b0;
    if (tb_req_valid && !tb_req_retry) begin
      if (tb_req_we) begin
        mem[tb_req_pos] <= tb_req_data;
        wr_cnt <= wr_cnt + 1;
      end else begin
        tb_ack_valid <= 1'b1;
        tb_ack_data  <= mem[tb_req_pos];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_core(input logic [REQ_BITS-1:0] typ, input logic [POS_W-1:0] pos,
                            input logic [TAG_W-1:0] tag, output int t_grant);
    core_req_valid = 1'b1;
    core_req_type  = typ;
    core_req_pos   = pos;
    core_req_tag   = tag;
    t_grant = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!core_req_retry) begin
        @(posedge clk); #1;
        t_grant = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (t_grant < 0) chk("core_accept_timeout", 32'(core_req_retry), 32'd0);
    core_req_valid = 1'b0;
  endtask

  task automatic wait_ack(output int t_ack);
    t_ack = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_ack_valid) begin
        t_ack = cyc;
        break;
      end
    end
    if (t_ack < 0) chk("ack_timeout", 32'(core_ack_valid), 32'd1);
  endtask

  task automatic do_fill(input logic [POS_W-1:0] pos, input logic [ENTRY_W-1:0] data);
    bit acc;
    acc = 1'b0;
    fill_req_valid = 1'b1;
    fill_req_pos   = pos;
    fill_req_data  = data;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!fill_req_retry) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("fill_accept_timeout", 32'(fill_req_retry), 32'd0);
    @(posedge clk); #1;
    fill_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int tg, ta, w0, r0, nf;
    bit got, saw;
    reset = 1'b1;
    core_req_valid = 1'b1; core_req_type = '0; core_req_pos = '0; core_req_tag = '0;
    fill_req_valid = 1'b1; fill_req_pos = '0; fill_req_data = '0;
    core_ack_retry = 1'b0; tb_req_retry = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_core_req_retry", 32'(core_req_retry), 32'd1);
    chk("rst_fill_req_retry", 32'(fill_req_retry), 32'd1);
    chk("rst_tb_req_valid", 32'(tb_req_valid), 32'd0);
    chk("rst_core_ack_valid", 32'(core_ack_valid), 32'd0);
    chk("rst_core_ack_hit", 32'(core_ack_hit), 32'd0);
    chk("rst_core_ack_state", 32'(core_ack_state), 32'd0);
    @(posedge clk); #1;
    core_req_valid = 1'b0; fill_req_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    // Fill pos 5: state E, lru 0, tag 0x1A2B3
    do_fill(5'd5, 24'h41A2B3);
    chk("fill_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("fill_mem5", 32'(mem[5]), 32'h41A2B3);

    // L64U hit on E: state unchanged, lru refreshed to 3
    w0 = wr_cnt;
    issue_core(CORE_LOP_L64U, 5'd5, 18'h1A2B3, tg);
    wait_ack(ta);
    chk("l64u_hit", 32'(core_ack_hit), 32'd1);
    chk("l64u_state", 32'(core_ack_state), 32'(ST_E));
    chk("l64u_latency", 32'(ta - tg), SKIPWR ? 32'd2 : 32'd3);
    @(posedge clk); #1;
    chk("l64u_writes", 32'(wr_cnt - w0), SKIPWR ? 32'd0 : 32'd1);
    chk("l64u_mem5", 32'(mem[5]), SKIPWR ? 32'h41A2B3 : 32'h59A2B3);

    // MOP_COMMIT on US -> S, spare bit preserved
    do_fill(5'd7, 24'h640042);
    issue_core(CORE_MOP_COMMIT, 5'd7, 18'h00042, tg);
    wait_ack(ta);
    chk("commit_hit", 32'(core_ack_hit), 32'd1);
    chk("commit_state", 32'(core_ack_state), 32'(ST_S));
    @(posedge clk); #1;
    chk("commit_mem7", 32'(mem[7]), 32'h3C0042);
    issue_core(CORE_LOP_L08U, 5'd7, 18'h00042, tg);
    wait_ack(ta);
    chk("reread_hit", 32'(core_ack_hit), 32'd1);
    chk("reread_state", 32'(core_ack_state), 32'(ST_S));
    @(posedge clk); #1;

    // Tag mismatch: no write, one cycle earlier, old state returned
    w0 = wr_cnt;
    issue_core(CORE_LOP_L64U, 5'd5, 18'h00001, tg);
    wait_ack(ta);
    chk("miss_hit", 32'(core_ack_hit), 32'd0);
    chk("miss_state", 32'(core_ack_state), 32'(ST_E));
    chk("miss_latency", 32'(ta - tg), 32'd2);
    @(posedge clk); #1;
    chk("miss_writes", 32'(wr_cnt - w0), 32'd0);

    // MOP_BEGIN on UM -> US, then KILL -> I, then lookup misses
    do_fill(5'd9, 24'h83FFFF);
    issue_core(CORE_MOP_BEGIN, 5'd9, 18'h3FFFF, tg);
    wait_ack(ta);
    chk("begin_state", 32'(core_ack_state), 32'(ST_US));
    @(posedge clk); #1;
    chk("begin_mem9", 32'(mem[9]), 32'h7BFFFF);
    issue_core(CORE_MOP_KILL, 5'd9, 18'h3FFFF, tg);
    wait_ack(ta);
    chk("kill_hit", 32'(core_ack_hit), 32'd1);
    chk("kill_state", 32'(core_ack_state), 32'(ST_I));
    @(posedge clk); #1;
    chk("kill_mem9", 32'(mem[9]), 32'h1BFFFF);
    issue_core(CORE_LOP_L08U, 5'd9, 18'h3FFFF, tg);
    wait_ack(ta);
    chk("inval_hit", 32'(core_ack_hit), 32'd0);
    @(posedge clk); #1;

    // Continuous fills starve the core for exactly four IDLE grants
    fill_req_valid = 1'b1; fill_req_pos = 5'd20; fill_req_data = 24'h0000AA;
    core_req_valid = 1'b1; core_req_type = CORE_LOP_L64U; core_req_pos = 5'd5;
    core_req_tag = 18'h1A2B3;
    nf = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!core_req_retry) begin got = 1'b1; break; end
      if (!fill_req_retry) nf++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    chk("stall1_core_won", 32'(got), 32'd1);
    chk("stall1_fills", 32'(nf), 32'd4);
    wait_ack(ta);
    chk("stall1_hit", 32'(core_ack_hit), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fill_after_resp", 32'(fill_req_retry), 32'd0);
    @(posedge clk); #1;
    core_req_valid = 1'b1;
    nf = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!core_req_retry) begin got = 1'b1; break; end
      if (!fill_req_retry) nf++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    core_req_valid = 1'b0; fill_req_valid = 1'b0;
    chk("stall2_fills", 32'(nf), 32'd4);
    wait_ack(ta);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Bank busy 3 cycles in RD, core busy 2 cycles in RESP
    r0 = rd_cnt; w0 = wr_cnt;
    tb_req_retry = 1'b1; core_ack_retry = 1'b1;
    issue_core(CORE_LOP_L08U, 5'd7, 18'h00042, tg);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_hold_valid", 32'(tb_req_valid), 32'd1);
      chk("rd_hold_we", 32'(tb_req_we), 32'd0);
      chk("rd_hold_pos", 32'(tb_req_pos), 32'd7);
      @(posedge clk); #1;
    end
    tb_req_retry = 1'b0;
    wait_ack(ta);
    chk("resp_hold0_state", 32'(core_ack_state), 32'(ST_S));
    chk("resp_hold0_tbretry", 32'(tb_ack_retry), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_hold1_valid", 32'(core_ack_valid), 32'd1);
    chk("resp_hold1_hit", 32'(core_ack_hit), 32'd1);
    chk("resp_hold1_tbretry", 32'(tb_ack_retry), 32'd1);
    @(posedge clk); #1;
    core_ack_retry = 1'b0;
    @(negedge clk);
    chk("resp_release_valid", 32'(core_ack_valid), 32'd1);
    chk("resp_release_tbretry", 32'(tb_ack_retry), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_done_valid", 32'(core_ack_valid), 32'd0);
    chk("retry_reads", 32'(rd_cnt - r0), 32'd1);
    chk("retry_writes", 32'(wr_cnt - w0), SKIPWR ? 32'd0 : 32'd1);
    @(posedge clk); #1;

    // Reset while waiting for bank data abandons the lookup
    w0 = wr_cnt;
    issue_core(CORE_LOP_L08U, 5'd5, 18'h1A2B3, tg);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", 32'(core_req_retry), 32'd0);
    chk("rst_mid_tb_req_valid", 32'(tb_req_valid), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw = saw | core_ack_valid | (tb_req_valid & tb_req_we);
    end
    chk("rst_mid_no_ack_or_write", 32'(saw), 32'd0);
    chk("rst_mid_writes", 32'(wr_cnt - w0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
